williams_input_ctrl: RTL and testbench
======================================

Name: williams_input_ctrl

Overview:
Input conditioning stage directly upstream of williams_cpu. It turns hps_io keyboard events (ps2_key) and the two MiSTer joysticks into the registered SW[7:0] and JA/JB[8:0] vectors the CPU board samples. It adds three things a plain key decoder lacks: per-key hold tracking, so shared functions stay asserted while any of their keys is held; a coin pulse shaper with enforced low gap; and clean reset/first-event handling.

Parameters:
COIN_PULSE_CYC, 24'd1200000, clk_sys cycles the coin line is held high (~50 ms at 24 MHz)
COIN_GAP_CYC, 24'd1200000, minimum clk_sys cycles the coin line stays low after a pulse

Ports:
clk_sys  in  1  system clock; all logic on its rising edge
I_RESET_N  in  1  asynchronous, active-low reset
ps2_key  in  11  hps_io key event: [10] toggle, [9] pressed, [8] extended, [7:0] scancode
joy_0  in  16  joystick 0 buttons (hps_io bit order)
joy_1  in  16  joystick 1 buttons
sw  out  8  {start1, slam, coin, 0, 0, hsreset, advance, autoup} to williams_cpu SW
jc  out  9  {start2, inviso, up, down, reverse, hyperspace, smartbomb, thrust, fire} to williams_cpu JA and JB

Behaviour:
- Reset, asynchronous: sw=0, jc=0, all key-hold flops 0, coin FSM in IDLE with pending=0 and counter=0. Toggle shadow tgl_q is cleared and armed=0.
- First clock after reset release: tgl_q<=ps2_key[10], armed<=1, no event is decoded, so a stale toggle never produces a phantom key.
- Event: armed && ps2_key[10]!=tgl_q. On that clock tgl_q<=ps2_key[10] and the matching hold flop is set to ps2_key[9].
- One hold flop per physical key. Key map is {ext,code}; ext must be 0 unless noted:
  01D W, 014 Ctrl -> fire
  01C A, 011 Alt -> smartbomb
  023 D -> hyperspace
  01B S, 6B left, 74 right -> thrust (left/right: ext don't-care)
  75 up -> up; 72 down -> down (ext don't-care)
  029 Space -> reverse
  012 LShift, 059 RShift -> inviso
  005 F1, 016 '1' -> start1
  006 F2, 01E '2' -> start2
  004 F3, 00C F4, 02E '5' -> coin source
  076 Esc -> slam; 083 F7 -> hsreset; 001 F9 -> autoup; 009 F10 -> advance
  Unmapped codes: no effect.
- Each function is the OR of its hold flops. Releasing one key of a shared function leaves the function asserted while any other of its keys is held.
- joy = joy_0|joy_1, ORed in per bit: joy[0]|joy[1] -> thrust, joy[2] down, joy[3] up, joy[4] fire, joy[5] smartbomb, joy[6] reverse, joy[7] inviso, joy[8] hyperspace, joy[9] start1, joy[10] start2.
- joy[9]|joy[10] is also a coin source.
- sw/jc are registered. Key effect appears 2 clocks after the ps2_key change; joystick effect appears 1 clock after.
- Coin shaper:
  - coin_src = OR of coin-key flops, joy[9], joy[10]. A rising edge is detected against a 1-clock delayed copy.
  - IDLE: on edge -> PULSE and load counter.
  - PULSE: coin=1 for exactly COIN_PULSE_CYC clocks -> GAP.
  - GAP: coin=0 for exactly COIN_GAP_CYC clocks. Then -> PULSE if pending (clear pending), else IDLE.
  - An edge during PULSE or GAP sets pending. Only one edge is queued; further edges are dropped.
  - An edge coinciding with the GAP->IDLE transition counts as pending.
  - Counters are 24-bit down-counters, reloaded on state entry; they saturate at 0.
- sw[4:3] are always 0.

Decomposition:
- williams_input_pkg: scancode localparams, sw/jc bit-index localparams, coin_state_t enum {IDLE, PULSE, GAP}.
- One sub-module, williams_coin_pulser: edge detect, FSM, counter, pending flag. Its interface is clk_sys, I_RESET_N, src, coin. It carries both parameters.

Test Plan:
- ps2_key toggle with {pressed=1, code 01D}, later toggle with pressed=0 -> jc[0] rises 2 clocks after press and falls 2 clocks after release; all other bits stay 0.
- Press S (01B) then left (16B), release left -> jc[1] stays 1; release S -> jc[1]=0 2 clocks later.
- With COIN_PULSE_CYC=8 and COIN_GAP_CYC=4, press F3 -> sw[5] high exactly 8 clocks starting 2 clocks after the edge; no retrigger while F3 is held.
- Same parameters: '5' edges at pulse clock 3 and pulse clock 5 -> second pulse begins exactly 4 clocks after the first ends; the third edge is dropped, so 2 pulses total.
- joy_1[4]=1 -> jc[0]=1 after 1 clock. joy_0[9]=1 -> sw[7]=1 after 1 clock plus one coin pulse.
- Assert I_RESET_N=0 mid-pulse -> sw and jc are 0 immediately. Release with ps2_key[10] differing from its pre-reset value -> no bit asserts.

Source files
------------

// File: rtl/williams_input_pkg.sv
// Shared definitions for the Williams input conditioning stage: scancodes,
// per-key hold indices, SW/JC bit positions and the coin shaper states.
package williams_input_pkg;

    localparam logic [7:0] SC_W      = 8'h1D;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_A      = 8'h1C;
    localparam logic [7:0] SC_ALT    = 8'h11;
    localparam logic [7:0] SC_D      = 8'h23;
    localparam logic [7:0] SC_S      = 8'h1B;
    localparam logic [7:0] SC_LEFT   = 8'h6B;
    localparam logic [7:0] SC_RIGHT  = 8'h74;
    localparam logic [7:0] SC_UP     = 8'h75;
    localparam logic [7:0] SC_DOWN   = 8'h72;
    localparam logic [7:0] SC_SPACE  = 8'h29;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_F1     = 8'h05;
    localparam logic [7:0] SC_1      = 8'h16;
    localparam logic [7:0] SC_F2     = 8'h06;
    localparam logic [7:0] SC_2      = 8'h1E;
    localparam logic [7:0] SC_F3     = 8'h04;
    localparam logic [7:0] SC_F4     = 8'h0C;
    localparam logic [7:0] SC_5      = 8'h2E;
    localparam logic [7:0] SC_ESC    = 8'h76;
    localparam logic [7:0] SC_F7     = 8'h83;
    localparam logic [7:0] SC_F9     = 8'h01;
    localparam logic [7:0] SC_F10    = 8'h09;

    localparam int NUM_KEYS = 24;

    localparam logic [4:0] KEY_W      = 5'd0;
    localparam logic [4:0] KEY_CTRL   = 5'd1;
    localparam logic [4:0] KEY_A      = 5'd2;
    localparam logic [4:0] KEY_ALT    = 5'd3;
    localparam logic [4:0] KEY_D      = 5'd4;
    localparam logic [4:0] KEY_S      = 5'd5;
    localparam logic [4:0] KEY_LEFT   = 5'd6;
    localparam logic [4:0] KEY_RIGHT  = 5'd7;
    localparam logic [4:0] KEY_UP     = 5'd8;
    localparam logic [4:0] KEY_DOWN   = 5'd9;
    localparam logic [4:0] KEY_SPACE  = 5'd10;
    localparam logic [4:0] KEY_LSHIFT = 5'd11;
    localparam logic [4:0] KEY_RSHIFT = 5'd12;
    localparam logic [4:0] KEY_F1     = 5'd13;
    localparam logic [4:0] KEY_1      = 5'd14;
    localparam logic [4:0] KEY_F2     = 5'd15;
    localparam logic [4:0] KEY_2      = 5'd16;
    localparam logic [4:0] KEY_F3     = 5'd17;
    localparam logic [4:0] KEY_F4     = 5'd18;
    localparam logic [4:0] KEY_5      = 5'd19;
    localparam logic [4:0] KEY_ESC    = 5'd20;
    localparam logic [4:0] KEY_F7     = 5'd21;
    localparam logic [4:0] KEY_F9     = 5'd22;
    localparam logic [4:0] KEY_F10    = 5'd23;

    localparam int SW_AUTOUP  = 0;
    localparam int SW_ADVANCE = 1;
    localparam int SW_HSRESET = 2;
    localparam int SW_COIN    = 5;
    localparam int SW_SLAM    = 6;
    localparam int SW_START1  = 7;

    localparam int JC_FIRE    = 0;
    localparam int JC_THRUST  = 1;
    localparam int JC_SMART   = 2;
    localparam int JC_HYPER   = 3;
    localparam int JC_REVERSE = 4;
    localparam int JC_DOWN    = 5;
    localparam int JC_UP      = 6;
    localparam int JC_INVISO  = 7;
    localparam int JC_START2  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } coin_state_t;

    typedef struct packed {
        logic       hit;
        logic [4:0] idx;
    } key_sel_t;

    // Map {ext, code} to a hold-flop index; arrow keys ignore the extended flag.
    function automatic key_sel_t decode_key(input logic ext, input logic [7:0] code);
        key_sel_t sel;
        sel.hit = ~ext;
        sel.idx = 5'd0;
        case (code)
            SC_W:      sel.idx = KEY_W;
            SC_CTRL:   sel.idx = KEY_CTRL;
            SC_A:      sel.idx = KEY_A;
            SC_ALT:    sel.idx = KEY_ALT;
            SC_D:      sel.idx = KEY_D;
            SC_S:      sel.idx = KEY_S;
            SC_LEFT:   begin sel.idx = KEY_LEFT;  sel.hit = 1'b1; end
            SC_RIGHT:  begin sel.idx = KEY_RIGHT; sel.hit = 1'b1; end
            SC_UP:     begin sel.idx = KEY_UP;    sel.hit = 1'b1; end
            SC_DOWN:   begin sel.idx = KEY_DOWN;  sel.hit = 1'b1; end
            SC_SPACE:  sel.idx = KEY_SPACE;
            SC_LSHIFT: sel.idx = KEY_LSHIFT;
            SC_RSHIFT: sel.idx = KEY_RSHIFT;
            SC_F1:     sel.idx = KEY_F1;
            SC_1:      sel.idx = KEY_1;
            SC_F2:     sel.idx = KEY_F2;
            SC_2:      sel.idx = KEY_2;
            SC_F3:     sel.idx = KEY_F3;
            SC_F4:     sel.idx = KEY_F4;
            SC_5:      sel.idx = KEY_5;
            SC_ESC:    sel.idx = KEY_ESC;
            SC_F7:     sel.idx = KEY_F7;
            SC_F9:     sel.idx = KEY_F9;
            SC_F10:    sel.idx = KEY_F10;
            default:   sel.hit = 1'b0;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/williams_coin_pulser.sv
// Coin pulse shaper: fixed-length high pulse followed by an enforced low gap,
// with a single queued request for edges that arrive while busy.
module williams_coin_pulser
    import williams_input_pkg::*;
#(
    parameter logic [23:0] COIN_PULSE_CYC = 24'd1200000,
    parameter logic [23:0] COIN_GAP_CYC   = 24'd1200000
) (
    input  logic clk_sys,
    input  logic I_RESET_N,
    input  logic src,
    output logic coin
);

    localparam logic [23:0] PULSE_LOAD = (COIN_PULSE_CYC == 24'd0) ? 24'd0 : COIN_PULSE_CYC - 24'd1;
    localparam logic [23:0] GAP_LOAD   = (COIN_GAP_CYC == 24'd0) ? 24'd0 : COIN_GAP_CYC - 24'd1;

    coin_state_t state_r, state_nxt_s;
    logic [23:0] cnt_r, cnt_nxt_s, cnt_dec_s;
    logic        pend_r, pend_nxt_s;
    logic        src_d_r;
    logic        edge_s;

    assign edge_s    = src & ~src_d_r;
    assign cnt_dec_s = (cnt_r == 24'd0) ? 24'd0 : cnt_r - 24'd1;
    assign coin      = (state_r == PULSE);

    // State, counter, pending flag and source delay registers
    always_ff @(posedge clk_sys or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            state_r <= IDLE;
            cnt_r   <= 24'd0;
            pend_r  <= 1'b0;
            src_d_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            pend_r  <= pend_nxt_s;
            src_d_r <= src;
        end
    end

    // Next-state logic; the gap's last clock also accepts a fresh edge
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_dec_s;
        pend_nxt_s  = pend_r;
        case (state_r)
            IDLE: begin
                if (edge_s) begin
                    state_nxt_s = PULSE;
                    cnt_nxt_s   = PULSE_LOAD;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            PULSE: begin
                if (edge_s) begin
                    pend_nxt_s = 1'b1;
                end else begin
                    pend_nxt_s = pend_r;
                end
                if (cnt_r == 24'd0) begin
                    state_nxt_s = GAP;
                    cnt_nxt_s   = GAP_LOAD;
                end else begin
                    state_nxt_s = PULSE;
                end
            end
            GAP: begin
                if (cnt_r == 24'd0) begin
                    if (pend_r || edge_s) begin
                        state_nxt_s = PULSE;
                        cnt_nxt_s   = PULSE_LOAD;
                        pend_nxt_s  = 1'b0;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else if (edge_s) begin
                    pend_nxt_s = 1'b1;
                end else begin
                    pend_nxt_s = pend_r;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = 24'd0;
                pend_nxt_s  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/williams_input_ctrl.sv
// Keyboard/joystick conditioning for williams_cpu: per-key hold tracking,
// joystick merge and coin shaping into registered SW and JA/JB vectors.
module williams_input_ctrl
    import williams_input_pkg::*;
#(
    parameter logic [23:0] COIN_PULSE_CYC = 24'd1200000,
    parameter logic [23:0] COIN_GAP_CYC   = 24'd1200000
) (
    input  logic        clk_sys,
    input  logic        I_RESET_N,
    input  logic [10:0] ps2_key,
    input  logic [15:0] joy_0,
    input  logic [15:0] joy_1,
    output logic [7:0]  sw,
    output logic [8:0]  jc
);

    logic                tgl_q_r;
    logic                armed_r;
    logic [NUM_KEYS-1:0] key_hold_r;
    logic                event_s;
    key_sel_t            key_sel_s;
    logic [10:0]         joy_s;
    logic                coin_src_s;
    logic                coin_s;
    logic [7:0]          sw_nxt_s;
    logic [8:0]          jc_nxt_s;
    logic                joy_unused_s;

    assign joy_unused_s = ^{joy_0[15:11], joy_1[15:11]};
    assign joy_s        = joy_0[10:0] | joy_1[10:0];
    assign key_sel_s    = decode_key(ps2_key[8], ps2_key[7:0]);
    // The first clock after reset only captures the toggle, so a stale toggle is ignored
    assign event_s      = armed_r && (ps2_key[10] != tgl_q_r);

    // Toggle shadow, arming flag and per-key hold flops
    always_ff @(posedge clk_sys or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            tgl_q_r    <= 1'b0;
            armed_r    <= 1'b0;
            key_hold_r <= {NUM_KEYS{1'b0}};
        end else begin
            tgl_q_r <= ps2_key[10];
            armed_r <= 1'b1;
            if (event_s && key_sel_s.hit) begin
                key_hold_r[key_sel_s.idx] <= ps2_key[9];
            end
        end
    end

    // Each function is the OR of its keys and joystick bits
    always_comb begin
        jc_nxt_s = 9'd0;
        sw_nxt_s = 8'd0;
        jc_nxt_s[JC_FIRE]    = key_hold_r[KEY_W] | key_hold_r[KEY_CTRL] | joy_s[4];
        jc_nxt_s[JC_THRUST]  = key_hold_r[KEY_S] | key_hold_r[KEY_LEFT] | key_hold_r[KEY_RIGHT]
                             | joy_s[0] | joy_s[1];
        jc_nxt_s[JC_SMART]   = key_hold_r[KEY_A] | key_hold_r[KEY_ALT] | joy_s[5];
        jc_nxt_s[JC_HYPER]   = key_hold_r[KEY_D] | joy_s[8];
        jc_nxt_s[JC_REVERSE] = key_hold_r[KEY_SPACE] | joy_s[6];
        jc_nxt_s[JC_DOWN]    = key_hold_r[KEY_DOWN] | joy_s[2];
        jc_nxt_s[JC_UP]      = key_hold_r[KEY_UP] | joy_s[3];
        jc_nxt_s[JC_INVISO]  = key_hold_r[KEY_LSHIFT] | key_hold_r[KEY_RSHIFT] | joy_s[7];
        jc_nxt_s[JC_START2]  = key_hold_r[KEY_F2] | key_hold_r[KEY_2] | joy_s[10];
        sw_nxt_s[SW_START1]  = key_hold_r[KEY_F1] | key_hold_r[KEY_1] | joy_s[9];
        sw_nxt_s[SW_SLAM]    = key_hold_r[KEY_ESC];
        sw_nxt_s[SW_COIN]    = coin_s;
        sw_nxt_s[SW_HSRESET] = key_hold_r[KEY_F7];
        sw_nxt_s[SW_ADVANCE] = key_hold_r[KEY_F10];
        sw_nxt_s[SW_AUTOUP]  = key_hold_r[KEY_F9];
        coin_src_s = key_hold_r[KEY_F3] | key_hold_r[KEY_F4] | key_hold_r[KEY_5]
                   | joy_s[9] | joy_s[10];
    end

    williams_coin_pulser #(
        .COIN_PULSE_CYC (COIN_PULSE_CYC),
        .COIN_GAP_CYC   (COIN_GAP_CYC)
    ) u_coin (
        .clk_sys   (clk_sys),
        .I_RESET_N (I_RESET_N),
        .src       (coin_src_s),
        .coin      (coin_s)
    );

    // Registered outputs to the CPU board
    always_ff @(posedge clk_sys or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            sw <= 8'd0;
            jc <= 9'd0;
        end else begin
            sw <= sw_nxt_s;
            jc <= jc_nxt_s;
        end
    end

endmodule

// File: tb/tb_williams_input_ctrl.sv
// Self-checking bench for williams_input_ctrl: vector table, hand-written coin
// and reset sequences, and randomized stimulus against a behavioural model.
module tb_williams_input_ctrl;

    localparam int P = 8;
    localparam int G = 4;

    logic        clk_sys;
    logic        rst_n;
    logic [10:0] ps2_key;
    logic [15:0] joy_0;
    logic [15:0] joy_1;
    logic [7:0]  sw;
    logic [8:0]  jc;

    int n_cmp = 0;
    int n_bad = 0;

    williams_input_ctrl #(
        .COIN_PULSE_CYC (24'd8),
        .COIN_GAP_CYC   (24'd4)
    ) dut (
        .clk_sys   (clk_sys),
        .I_RESET_N (rst_n),
        .ps2_key   (ps2_key),
        .joy_0     (joy_0),
        .joy_1     (joy_1),
        .sw        (sw),
        .jc        (jc)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    // ---------------- behavioural reference model ----------------
    // Function vector layout: [8:0] JC bits, [16:9] SW bits, [17] coin source.
    int km_key [24] = '{'h01D, 'h014, 'h01C, 'h011, 'h023, 'h01B, 'h06B, 'h074,
                        'h075, 'h072, 'h029, 'h012, 'h059, 'h005, 'h016, 'h006,
                        'h01E, 'h004, 'h00C, 'h02E, 'h076, 'h083, 'h001, 'h009};
    int km_fv  [24] = '{0, 0, 2, 2, 3, 1, 1, 1,
                        6, 5, 4, 7, 7, 16, 16, 8,
                        8, 17, 17, 17, 15, 11, 9, 10};
    int jm_fv  [11] = '{1, 1, 5, 6, 0, 2, 4, 7, 3, 16, 8};

    bit          held_m [512];
    bit          armed_m, tgl_m, src_prev_m, queued_m, coin_q_m;
    int          mcyc, pulse_start_m, free_at_m;
    logic [7:0]  exp_sw;
    logic [8:0]  exp_jc;

    task automatic model_reset();
        foreach (held_m[i]) held_m[i] = 1'b0;
        armed_m = 1'b0; tgl_m = 1'b0; src_prev_m = 1'b0;
        queued_m = 1'b0; coin_q_m = 1'b0;
        mcyc = 0; pulse_start_m = -1000; free_at_m = 0;
    endtask

    task automatic model_start_pulse();
        pulse_start_m = mcyc;
        free_at_m     = mcyc + P + G;
    endtask

    // One rising edge of clk_sys as seen by the model
    task automatic model_edge();
        logic [17:0] fv;
        logic [10:0] jv;
        bit src, rise, started, ext_c;
        if (!rst_n) begin
            model_reset();
            exp_sw = 8'd0;
            exp_jc = 9'd0;
            return;
        end
        jv = joy_0[10:0] | joy_1[10:0];
        fv = 18'd0;
        for (int i = 0; i < 24; i++) if (held_m[km_key[i]]) fv[km_fv[i]] = 1'b1;
        for (int b = 0; b < 11; b++) if (jv[b]) fv[jm_fv[b]] = 1'b1;
        if (jv[9] | jv[10]) fv[17] = 1'b1;
        exp_jc = fv[8:0];
        exp_sw = {fv[16], fv[15], coin_q_m, 2'b00, fv[11], fv[10], fv[9]};
        src = fv[17];
        rise = src && !src_prev_m;
        src_prev_m = src;
        started = 1'b0;
        if (queued_m && mcyc == free_at_m) begin
            model_start_pulse();
            queued_m = 1'b0;
            started = 1'b1;
        end
        if (rise && !started) begin
            if (mcyc >= free_at_m) model_start_pulse();
            else if (!queued_m) queued_m = 1'b1;
        end
        coin_q_m = (mcyc >= pulse_start_m) && (mcyc < pulse_start_m + P);
        if (armed_m && ps2_key[10] != tgl_m) begin
            ext_c = ps2_key[8];
            if (ps2_key[7:0] inside {8'h6B, 8'h74, 8'h75, 8'h72}) ext_c = 1'b0;
            held_m[{ext_c, ps2_key[7:0]}] = ps2_key[9];
        end
        tgl_m = ps2_key[10];
        armed_m = 1'b1;
        mcyc++;
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        model_edge();
        #1;
        check("model_sw", {56'd0, sw}, {56'd0, exp_sw});
        check("model_jc", {55'd0, jc}, {55'd0, exp_jc});
    endtask

    task automatic key_ev(input logic pr, input logic ext, input logic [7:0] code);
        ps2_key = {~ps2_key[10], pr, ext, code};
    endtask

    typedef struct {
        logic        ev;
        logic        pr;
        logic        ext;
        logic [7:0]  code;
        logic [15:0] j0;
        logic [15:0] j1;
        logic [7:0]  sw_e;
        logic [8:0]  jc_e;
    } vec_t;

    vec_t vt [21];
    logic [7:0] codes [28] = '{8'h1D, 8'h14, 8'h1C, 8'h11, 8'h23, 8'h1B, 8'h6B, 8'h74,
                               8'h75, 8'h72, 8'h29, 8'h12, 8'h59, 8'h05, 8'h16, 8'h06,
                               8'h1E, 8'h04, 8'h0C, 8'h2E, 8'h76, 8'h83, 8'h01, 8'h09,
                               8'h15, 8'h00, 8'hFF, 8'h5A};

    initial begin
        int first, cnt, pulses;
        logic [63:0] act_v, exp_v;
        logic prev;

        vt = '{
            '{1'b1, 1'b1, 1'b0, 8'h1D, 16'h0000, 16'h0000, 8'h00, 9'h001},
            '{1'b1, 1'b0, 1'b0, 8'h1D, 16'h0000, 16'h0000, 8'h00, 9'h000},
            '{1'b1, 1'b1, 1'b0, 8'h1B, 16'h0000, 16'h0000, 8'h00, 9'h002},
            '{1'b1, 1'b1, 1'b1, 8'h6B, 16'h0000, 16'h0000, 8'h00, 9'h002},
            '{1'b1, 1'b0, 1'b0, 8'h6B, 16'h0000, 16'h0000, 8'h00, 9'h002},
            '{1'b1, 1'b0, 1'b0, 8'h1B, 16'h0000, 16'h0000, 8'h00, 9'h000},
            '{1'b1, 1'b1, 1'b0, 8'h29, 16'h0000, 16'h0000, 8'h00, 9'h010},
            '{1'b1, 1'b1, 1'b1, 8'h14, 16'h0000, 16'h0000, 8'h00, 9'h010},
            '{1'b1, 1'b0, 1'b0, 8'h29, 16'h0000, 16'h0000, 8'h00, 9'h000},
            '{1'b1, 1'b1, 1'b0, 8'h76, 16'h0000, 16'h0000, 8'h40, 9'h000},
            '{1'b1, 1'b1, 1'b0, 8'h09, 16'h0000, 16'h0000, 8'h42, 9'h000},
            '{1'b1, 1'b0, 1'b0, 8'h76, 16'h0000, 16'h0000, 8'h02, 9'h000},
            '{1'b1, 1'b0, 1'b0, 8'h09, 16'h0000, 16'h0000, 8'h00, 9'h000},
            '{1'b1, 1'b1, 1'b0, 8'h05, 16'h0000, 16'h0000, 8'h80, 9'h000},
            '{1'b1, 1'b0, 1'b0, 8'h05, 16'h0000, 16'h0010, 8'h00, 9'h001},
            '{1'b0, 1'b0, 1'b0, 8'h00, 16'h0101, 16'h0000, 8'h00, 9'h00A},
            '{1'b1, 1'b1, 1'b1, 8'h75, 16'h0000, 16'h0000, 8'h00, 9'h040},
            '{1'b1, 1'b0, 1'b0, 8'h75, 16'h0000, 16'h0000, 8'h00, 9'h000},
            '{1'b1, 1'b1, 1'b1, 8'h83, 16'h0000, 16'h0000, 8'h00, 9'h000},
            '{1'b1, 1'b1, 1'b0, 8'h83, 16'h0000, 16'h0000, 8'h04, 9'h000},
            '{1'b1, 1'b0, 1'b0, 8'h83, 16'h0000, 16'h0000, 8'h00, 9'h000}
        };

        rst_n = 1'b0; ps2_key = 11'd0; joy_0 = 16'd0; joy_1 = 16'd0;
        model_reset();
        repeat (2) tick();
        check("reset_sw", {56'd0, sw}, 64'd0);
        check("reset_jc", {55'd0, jc}, 64'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Vector table: each row settles for three clocks
        for (int i = 0; i < 21; i++) begin
            if (vt[i].ev) key_ev(vt[i].pr, vt[i].ext, vt[i].code);
            joy_0 = vt[i].j0;
            joy_1 = vt[i].j1;
            repeat (3) tick();
            check($sformatf("vec%0d_sw", i), {56'd0, sw}, {56'd0, vt[i].sw_e});
            check($sformatf("vec%0d_jc", i), {55'd0, jc}, {55'd0, vt[i].jc_e});
        end
        joy_0 = 16'd0; joy_1 = 16'd0;
        repeat (2) tick();

        // Key latency: W press reaches jc[0] on the second clock
        key_ev(1'b1, 1'b0, 8'h1D);
        tick();
        check("w_lat1", {63'd0, jc[0]}, 64'd0);
        tick();
        check("w_lat2", {63'd0, jc[0]}, 64'd1);
        key_ev(1'b0, 1'b0, 8'h1D);
        tick();
        check("w_rel1", {63'd0, jc[0]}, 64'd1);
        tick();
        check("w_rel2", {63'd0, jc[0]}, 64'd0);

        // F3 held: one pulse of P clocks starting at clock 3, no retrigger
        key_ev(1'b1, 1'b0, 8'h04);
        first = 0; cnt = 0;
        for (int t = 1; t <= 30; t++) begin
            tick();
            if (sw[5]) begin
                cnt++;
                if (first == 0) first = t;
            end
        end
        check("f3_start", 64'(first), 64'd3);
        check("f3_len", 64'(cnt), 64'(P));
        check("f3_others", {56'd0, sw & 8'hDF}, 64'd0);
        key_ev(1'b0, 1'b0, 8'h04);
        repeat (16) tick();

        // '5' edges during the pulse: one queued, one dropped
        act_v = 64'd0; exp_v = 64'd0; pulses = 0; prev = 1'b0;
        for (int t = 1; t <= 40; t++) begin
            if (t <= 6) key_ev(1'(t % 2), 1'b0, 8'h2E);
            tick();
            act_v[t] = sw[5];
            exp_v[t] = ((t >= 3) && (t <= 10)) || ((t >= 15) && (t <= 22));
            if (sw[5] && !prev) pulses++;
            prev = sw[5];
        end
        check("coin5_timeline", act_v, exp_v);
        check("coin5_pulses", 64'(pulses), 64'd2);

        // Joystick latency and joystick-driven coin
        joy_1 = 16'h0010;
        tick();
        check("joy_fire", {55'd0, jc}, 64'h001);
        joy_1 = 16'h0000;
        tick();
        check("joy_fire_off", {55'd0, jc}, 64'h000);
        joy_0 = 16'h0200;
        tick();
        check("joy_start1", {56'd0, sw}, 64'h80);
        act_v = 64'd0; exp_v = 64'd0;
        for (int t = 2; t <= 14; t++) begin
            tick();
            act_v[t] = sw[5];
            exp_v[t] = (t >= 2) && (t <= 9);
        end
        check("joy_coin", act_v, exp_v);
        joy_0 = 16'd0;
        repeat (10) tick();

        // Asynchronous reset mid-pulse, stale toggle on release
        key_ev(1'b1, 1'b0, 8'h1D);
        tick();
        key_ev(1'b1, 1'b0, 8'h0C);
        repeat (4) tick();
        check("pre_rst_jc", {55'd0, jc}, 64'h001);
        check("pre_rst_coin", {63'd0, sw[5]}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("rst_async_sw", {56'd0, sw}, 64'd0);
        check("rst_async_jc", {55'd0, jc}, 64'd0);
        ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h1D};
        repeat (2) tick();
        rst_n = 1'b1;
        for (int t = 0; t < 6; t++) begin
            tick();
            check("rst_stale", {47'd0, sw, jc}, 64'd0);
        end

        // Randomized stimulus against the model
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) rst_n = 1'b0;
            if (i == 1504) rst_n = 1'b1;
            case ($urandom_range(0, 7))
                0, 1: key_ev(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                             codes[$urandom_range(0, 27)]);
                2: ps2_key[9:0] = 10'($urandom);
                default: ;
            endcase
            if ($urandom_range(0, 15) == 0)
                joy_0 = ($urandom_range(0, 1) == 1) ? 16'd0 : 16'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 15) == 0)
                joy_1 = ($urandom_range(0, 1) == 1) ? 16'd0 : 16'($urandom & $urandom & $urandom);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
